// File: rtl/dlx_mem_pkg.sv
// Shared types for the DLX MEM-stage load/store unit: op and state encodings, size helpers.
// The MISALIGN_TRAP_EN macro is consumed by dlx_mem_stage; this package defines the misalignment rule.
package dlx_mem_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_CAPT = 3'd3,
      ST_WR   = 3'd4,
      ST_RESP = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   function automatic logic is_load(input mem_op_t op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic mem_size_t op_size(input mem_op_t op);
      mem_size_t sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   // Halfwords must sit on even addresses, words on multiples of four.
   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
      logic bad;
      case (op_size(op))
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dlx_lane_align.sv
// Big-endian lane logic: extract-and-extend for loads, merge of the store lane into a read word.
// Byte lane 0 is bits [31:24]; half lane 0 is bits [31:16].
module dlx_lane_align
   import dlx_mem_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] rdata_ext,
   output logic [31:0] wword
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'h00;
      case (addr)
         2'd0: lane_b = word[31:24];
         2'd1: lane_b = word[23:16];
         2'd2: lane_b = word[15:8];
         2'd3: lane_b = word[7:0];
      endcase
      lane_h = addr[1] ? word[15:0] : word[31:16];
   end

   always_comb begin
      rdata_ext = word;
      case (op)
         OP_LB:   rdata_ext = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  rdata_ext = {24'h000000, lane_b};
         OP_LH:   rdata_ext = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  rdata_ext = {16'h0000, lane_h};
         default: rdata_ext = word;
      endcase
   end

   // Sub-word stores keep the untouched lanes of the word just read back.
   always_comb begin
      wword = wdata;
      case (op_size(op))
         SZ_BYTE: begin
            wword = word;
            case (addr)
               2'd0: wword[31:24] = wdata[7:0];
               2'd1: wword[23:16] = wdata[7:0];
               2'd2: wword[15:8]  = wdata[7:0];
               2'd3: wword[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            wword = word;
            if (addr[1]) wword[15:0]  = wdata[15:0];
            else         wword[31:16] = wdata[15:0];
         end
         default: wword = wdata;
      endcase
   end

endmodule

// File: rtl/dlx_mem_stage.sv
// DLX MEM-stage load/store unit driving a word-wide syncram; sub-word stores use read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses without touching RAM.
module dlx_mem_stage
   import dlx_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misalign,
   output logic              stall,
   output logic              ram_cs,
   output logic              ram_oe,
   output logic              ram_we,
   output logic [31:0]       ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   output state_t            dbg_state
);

   localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

   state_t            state, state_nxt;
   mem_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wword_q;
   logic [1:0]        wait_cnt;
   logic              accept;
   logic              trap_req;
   logic              capt_load;
   logic [31:0]       rdata_ext;
   logic [31:0]       wword;

   // Handshake: a request is taken on a rising edge where req_valid & req_ready; req_ready is high
   // only in IDLE (including the resp_valid cycle), and the requester holds its request until taken.
   assign req_ready = (state == ST_IDLE);
   assign stall     = ~req_ready;
   assign accept    = req_valid & req_ready;
   assign capt_load = (state == ST_CAPT) && is_load(op_q);
   assign dbg_state = state;

`ifdef MISALIGN_TRAP_EN
   logic trap_q;

   assign trap_req = is_misaligned(mem_op_t'(req_op), req_addr[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         if (accept) trap_q <= trap_req;
         misalign <= (state == ST_RESP) && trap_q;
      end
   end
`else
   assign trap_req = 1'b0;
   assign misalign = 1'b0;
`endif

   dlx_lane_align u_lane_align (
      .op        (op_q),
      .addr      (addr_q[1:0]),
      .word      (ram_dout),
      .wdata     (wword_q),
      .rdata_ext (rdata_ext),
      .wword     (wword)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (trap_req)                          state_nxt = ST_RESP;
               else if (mem_op_t'(req_op) == OP_SW)   state_nxt = ST_WR;
               else                                   state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = (RD_LAT > 1) ? ST_WAIT : ST_CAPT;
         ST_WAIT: if (wait_cnt == 2'd1) state_nxt = ST_CAPT;
         ST_CAPT: state_nxt = is_store(op_q) ? ST_WR : ST_IDLE;
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // RAM strobes decode straight from state so an async reset drops them immediately.
   always_comb begin
      ram_cs   = (state == ST_RD) || (state == ST_WR);
      ram_oe   = (state == ST_RD);
      ram_we   = (state == ST_WR);
      ram_addr = 32'({addr_q[ADDR_W-1:2], 2'b00});
      ram_din  = (state == ST_WR) ? wword_q : 32'h0000_0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         op_q       <= OP_LB;
         addr_q     <= '0;
         wword_q    <= 32'h0000_0000;
         wait_cnt   <= 2'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
      end else begin
         state <= state_nxt;
         // wword_q holds the raw store data until CAPT replaces it with the merged word.
         if (accept) begin
            op_q    <= mem_op_t'(req_op);
            addr_q  <= req_addr;
            wword_q <= req_wdata;
         end
         if ((state == ST_CAPT) && is_store(op_q)) wword_q <= wword;
         if (state == ST_RD)        wait_cnt <= WAIT_LOAD;
         else if (state == ST_WAIT) wait_cnt <= wait_cnt - 2'd1;
         resp_valid <= capt_load || (state == ST_RESP);
         if (capt_load) resp_rdata <= rdata_ext;
      end
   end

endmodule

// File: tb/tb_dlx_mem_stage.sv
// Bench for dlx_mem_stage: instance A (RD_LAT=1) and instance B (RD_LAT=3), each with its own syncram model.
// Directed table, reset-abort sequence, and randomized traffic against an arithmetic reference model.
module tb_dlx_mem_stage;
   import dlx_mem_pkg::*;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_req_valid, a_req_ready, a_resp_valid, a_misalign, a_stall;
   logic        a_ram_cs, a_ram_oe, a_ram_we;
   logic [2:0]  a_req_op;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_ram_addr, a_ram_din, a_ram_dout;
   state_t      a_dbg_state;

   logic        b_req_valid, b_req_ready, b_resp_valid, b_misalign, b_stall;
   logic        b_ram_cs, b_ram_oe, b_ram_we;
   logic [2:0]  b_req_op;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_ram_addr, b_ram_din, b_ram_dout;
   state_t      b_dbg_state;

   dlx_mem_stage #(.ADDR_W(32), .RD_LAT(LAT_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_op(a_req_op), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .misalign(a_misalign), .stall(a_stall),
      .ram_cs(a_ram_cs), .ram_oe(a_ram_oe), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
      .ram_din(a_ram_din), .ram_dout(a_ram_dout), .dbg_state(a_dbg_state)
   );

   dlx_mem_stage #(.ADDR_W(32), .RD_LAT(LAT_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_op(b_req_op), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .misalign(b_misalign), .stall(b_stall),
      .ram_cs(b_ram_cs), .ram_oe(b_ram_oe), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
      .ram_din(b_ram_din), .ram_dout(b_ram_dout), .dbg_state(b_dbg_state)
   );

   // Syncram models: 16 words, backdoor preload port, read data valid RD_LAT cycles after the read.
   logic        bd_we;
   logic [3:0]  bd_idx;
   logic [31:0] bd_data;
   logic [31:0] mem_a [0:15];
   logic [31:0] mem_b [0:15];
   logic [31:0] b_pipe [0:2];

   always @(posedge clk) begin
      if (bd_we) mem_a[bd_idx] <= bd_data;
      else if (a_ram_cs && a_ram_we) mem_a[a_ram_addr[5:2]] <= a_ram_din;
      a_ram_dout <= (a_ram_cs && a_ram_oe) ? mem_a[a_ram_addr[5:2]] : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (bd_we) mem_b[bd_idx] <= bd_data;
      else if (b_ram_cs && b_ram_we) mem_b[b_ram_addr[5:2]] <= b_ram_din;
      b_pipe[0] <= (b_ram_cs && b_ram_oe) ? mem_b[b_ram_addr[5:2]] : 32'hDEAD_BEEF;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign b_ram_dout = b_pipe[LAT_B-1];

   // Per-cycle monitors: strobe counts, last written word, protocol violations.
   int a_cs_cnt = 0, a_we_cnt = 0, a_bad = 0;
   int b_cs_cnt = 0, b_we_cnt = 0, b_bad = 0;
   logic [31:0] a_last_din = 32'h0, b_last_din = 32'h0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (a_ram_cs) a_cs_cnt <= a_cs_cnt + 1;
         if (a_ram_cs && a_ram_we) begin a_we_cnt <= a_we_cnt + 1; a_last_din <= a_ram_din; end
         if ((a_ram_we && !a_ram_cs) || (a_ram_oe && !a_ram_cs) || (a_ram_oe && a_ram_we) ||
             (a_ram_cs && !a_ram_oe && !a_ram_we) || (a_stall == a_req_ready) ||
             (a_resp_valid && !a_req_ready) || (a_misalign && !a_resp_valid) ||
             (a_ram_cs && (a_ram_addr[1:0] != 2'b00 || a_ram_addr[31:6] != 26'h0)))
            a_bad <= a_bad + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (b_ram_cs) b_cs_cnt <= b_cs_cnt + 1;
         if (b_ram_cs && b_ram_we) begin b_we_cnt <= b_we_cnt + 1; b_last_din <= b_ram_din; end
         if ((b_ram_we && !b_ram_cs) || (b_ram_oe && !b_ram_cs) || (b_ram_oe && b_ram_we) ||
             (b_ram_cs && !b_ram_oe && !b_ram_we) || (b_stall == b_req_ready) ||
             (b_resp_valid && !b_req_ready) || (b_misalign && !b_resp_valid) ||
             (b_ram_cs && (b_ram_addr[1:0] != 2'b00 || b_ram_addr[31:6] != 26'h0)))
            b_bad <= b_bad + 1;
      end
   end

   // Scoreboard state and reference model.
   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_mem [0:1][0:15];
   logic [31:0] last_rdata [0:1];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic model_trap(input logic [2:0] op, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
      if (op == 3'd2 || op == 3'd3 || op == 3'd6) return (addr % 2) != 0;
      if (op == 3'd4 || op == 3'd7) return (addr % 4) != 0;
      return 1'b0;
`else
      return (op == 3'd8) && (addr != addr);
`endif
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] w, input logic [31:0] addr);
      int off;
      logic [31:0] b, h;
      off = int'(addr % 4);
      b = (w >> (8 * (3 - off))) & 32'hFF;
      h = (w >> (16 * (1 - off / 2))) & 32'hFFFF;
      case (op)
         3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
         3'd1: return b;
         3'd2: return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd3: return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] op, input logic [31:0] w,
                                               input logic [31:0] addr, input logic [31:0] wd);
      int off, sh;
      logic [31:0] mask;
      off = int'(addr % 4);
      if (op == 3'd5) begin
         sh = 8 * (3 - off);
         mask = 32'hFF << sh;
         return (w & ~mask) | ((wd & 32'hFF) << sh);
      end
      if (op == 3'd6) begin
         sh = 16 * (1 - off / 2);
         mask = 32'hFFFF << sh;
         return (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   function automatic logic ready_of(input int inst);  return (inst == 0) ? a_req_ready  : b_req_ready;  endfunction
   function automatic logic resp_of(input int inst);   return (inst == 0) ? a_resp_valid : b_resp_valid; endfunction
   function automatic logic stall_of(input int inst);  return (inst == 0) ? a_stall      : b_stall;      endfunction
   function automatic logic mis_of(input int inst);    return (inst == 0) ? a_misalign   : b_misalign;   endfunction
   function automatic logic [31:0] rdata_of(input int inst); return (inst == 0) ? a_resp_rdata : b_resp_rdata; endfunction
   function automatic logic [31:0] din_of(input int inst);   return (inst == 0) ? a_last_din   : b_last_din;   endfunction
   function automatic int cs_cnt_of(input int inst);   return (inst == 0) ? a_cs_cnt : b_cs_cnt; endfunction
   function automatic int we_cnt_of(input int inst);   return (inst == 0) ? a_we_cnt : b_we_cnt; endfunction

   task automatic drive_req(input int inst, input logic v, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wd);
      if (inst == 0) begin a_req_valid = v; a_req_op = op; a_req_addr = addr; a_req_wdata = wd; end
      else           begin b_req_valid = v; b_req_op = op; b_req_addr = addr; b_req_wdata = wd; end
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that raised resp_valid.
   task automatic do_txn(input int inst, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic ok, output int wait_cyc, output int lat, output int busy,
                         output logic [31:0] rdata, output logic mis, output int cs_d, output int we_d,
                         output logic [31:0] din);
      int cs0, we0;
      drive_req(inst, 1'b1, op, addr, wd);
      wait_cyc = 0;
      while (!ready_of(inst) && wait_cyc < 50) begin @(posedge clk); #1; wait_cyc++; end
      cs0 = cs_cnt_of(inst);
      we0 = we_cnt_of(inst);
      @(posedge clk); #1;
      drive_req(inst, 1'b0, op, addr, wd);
      lat = 0;
      busy = 0;
      while (!resp_of(inst) && lat < 40) begin
         if (stall_of(inst)) busy++;
         @(posedge clk); #1;
         lat++;
      end
      ok    = resp_of(inst);
      rdata = rdata_of(inst);
      mis   = mis_of(inst);
      cs_d  = cs_cnt_of(inst) - cs0;
      we_d  = we_cnt_of(inst) - we0;
      din   = din_of(inst);
   endtask

   task automatic run_check(input int inst, input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rdata, input int exp_lat,
                            input logic exp_mis, input logic [31:0] exp_din);
      logic ok, mis, trap, st;
      int wait_cyc, lat, busy, cs_d, we_d;
      logic [31:0] rdata, din;
      trap = model_trap(op, addr);
      st   = (op >= 3'd5);
      exp_q.push_back(exp_rdata);
      do_txn(inst, op, addr, wd, ok, wait_cyc, lat, busy, rdata, mis, cs_d, we_d, din);
      check32({tag, " accept_wait"}, wait_cyc, 0);
      check32({tag, " resp_valid"}, {31'h0, ok}, 32'd1);
      check32({tag, " rdata"}, rdata, exp_q.pop_front());
      check32({tag, " latency"}, lat, exp_lat);
      check32({tag, " misalign"}, {31'h0, mis}, {31'h0, exp_mis});
      check32({tag, " stall_cycles"}, busy, exp_lat);
      check32({tag, " ram_cs_cycles"}, cs_d, trap ? 0 : (op == 3'd7) ? 1 : st ? 2 : 1);
      check32({tag, " ram_we_cycles"}, we_d, (st && !trap) ? 1 : 0);
      if (st && !trap) begin
         check32({tag, " ram_din"}, din, exp_din);
         model_mem[inst][addr[5:2]] = model_store(op, model_mem[inst][addr[5:2]], addr, wd);
      end
      if (!st && !trap) last_rdata[inst] = exp_rdata;
   endtask

   task automatic rand_txn(input int inst, input int rd_lat, input string tag);
      logic [2:0]  op;
      logic [31:0] addr, wd, w, exp_rd;
      logic        trap;
      int          exp_lat;
      op   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
      wd   = $urandom;
      trap = model_trap(op, addr);
      w    = model_mem[inst][addr[5:2]];
      exp_rd  = (trap || op >= 3'd5) ? last_rdata[inst] : model_load(op, w, addr);
      exp_lat = trap ? 1 : (op == 3'd7) ? 2 : (op >= 3'd5) ? rd_lat + 3 : rd_lat + 1;
      run_check(inst, tag, op, addr, wd, exp_rd, exp_lat, trap, model_store(op, w, addr, wd));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        exp_mis;
      logic [31:0] exp_din;
   } vec_t;

   vec_t vecs [0:12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] w;
      logic        seen;
      int          we0;

      vecs[0]  = '{OP_LW,  32'h10, 32'h0,        32'h8899AABB, 2, 1'b0, 32'h0};
      vecs[1]  = '{OP_LB,  32'h11, 32'h0,        32'hFFFFFF99, 2, 1'b0, 32'h0};
      vecs[2]  = '{OP_LBU, 32'h11, 32'h0,        32'h00000099, 2, 1'b0, 32'h0};
      vecs[3]  = '{OP_LH,  32'h12, 32'h0,        32'hFFFFAABB, 2, 1'b0, 32'h0};
      vecs[4]  = '{OP_LHU, 32'h12, 32'h0,        32'h0000AABB, 2, 1'b0, 32'h0};
      vecs[5]  = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFF88, 2, 1'b0, 32'h0};
      vecs[6]  = '{OP_SB,  32'h13, 32'h000000CC, 32'hFFFFFF88, 4, 1'b0, 32'h8899AACC};
      vecs[7]  = '{OP_SH,  32'h10, 32'h00001234, 32'hFFFFFF88, 4, 1'b0, 32'h1234AACC};
      vecs[8]  = '{OP_LW,  32'h10, 32'h0,        32'h1234AACC, 2, 1'b0, 32'h0};
      vecs[9]  = '{OP_LHU, 32'h10, 32'h0,        32'h00001234, 2, 1'b0, 32'h0};
      vecs[10] = '{OP_SW,  32'h14, 32'hCAFEF00D, 32'h00001234, 2, 1'b0, 32'hCAFEF00D};
      vecs[11] = '{OP_LW,  32'h14, 32'h0,        32'hCAFEF00D, 2, 1'b0, 32'h0};
`ifdef MISALIGN_TRAP_EN
      vecs[12] = '{OP_LW,  32'h12, 32'h0,        32'hCAFEF00D, 1, 1'b1, 32'h0};
`else
      vecs[12] = '{OP_LW,  32'h12, 32'h0,        32'h1234AACC, 2, 1'b0, 32'h0};
`endif

      // Clock/reset and preload.
      rst_n = 1'b0;
      bd_we = 1'b0; bd_idx = 4'h0; bd_data = 32'h0;
      drive_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
      drive_req(1, 1'b0, 3'd0, 32'h0, 32'h0);
      last_rdata[0] = 32'h0;
      last_rdata[1] = 32'h0;
      for (int i = 0; i < 16; i++) begin
         w = (i == 4) ? 32'h8899AABB : $urandom;
         model_mem[0][i] = w;
         model_mem[1][i] = w;
         @(negedge clk);
         bd_we = 1'b1; bd_idx = 4'(i); bd_data = w;
      end
      @(negedge clk);
      bd_we = 1'b0;
      @(posedge clk); #1;

      check32("reset state", 32'(a_dbg_state), 32'(ST_IDLE));
      check32("reset req_ready", {31'h0, a_req_ready}, 32'd1);
      check32("reset resp_valid", {31'h0, a_resp_valid}, 32'd0);
      check32("reset resp_rdata", a_resp_rdata, 32'h0);
      check32("reset misalign", {31'h0, a_misalign}, 32'd0);
      check32("reset ram ctrl", {29'h0, a_ram_cs, a_ram_oe, a_ram_we}, 32'd0);
      check32("reset b ram ctrl", {29'h0, b_ram_cs, b_ram_oe, b_ram_we}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table on RD_LAT=1, issued back to back.
      for (int i = 0; i <= 12; i++)
         run_check(0, $sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wd,
                   vecs[i].exp_rdata, vecs[i].exp_lat, vecs[i].exp_mis, vecs[i].exp_din);

      // Reset during the CAPT cycle of an SB: nothing may reach the RAM or the response port.
      @(posedge clk); #1;
      we0 = a_we_cnt;
      drive_req(0, 1'b1, OP_SB, 32'h13, 32'h00000077);
      @(posedge clk); #1;
      drive_req(0, 1'b0, OP_SB, 32'h13, 32'h00000077);
      @(posedge clk); #1;
      check32("abort in CAPT", 32'(a_dbg_state), 32'(ST_CAPT));
      rst_n = 1'b0;
      #1;
      check32("abort ram ctrl", {29'h0, a_ram_cs, a_ram_oe, a_ram_we}, 32'd0);
      check32("abort resp_valid", {31'h0, a_resp_valid}, 32'd0);
      check32("abort resp_rdata", a_resp_rdata, 32'h0);
      last_rdata[0] = 32'h0;
      last_rdata[1] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin @(posedge clk); #1; seen |= a_resp_valid; end
      check32("abort no resp", {31'h0, seen}, 32'd0);
      check32("abort no write", a_we_cnt - we0, 32'd0);
      run_check(0, "after abort", OP_LW, 32'h10, 32'h0, 32'h1234AACC, 2, 1'b0, 32'h0);

      for (int n = 0; n < 150; n++) rand_txn(0, LAT_A, "rand_a");

      // RD_LAT=3: latency and two back-to-back loads with no lost request.
      run_check(1, "b lw", OP_LW, 32'h10, 32'h0, 32'h8899AABB, 4, 1'b0, 32'h0);
      run_check(1, "b b2b0", OP_LW, 32'h10, 32'h0, 32'h8899AABB, 4, 1'b0, 32'h0);
      run_check(1, "b b2b1", OP_LW, 32'h14, 32'h0, model_mem[1][5], 4, 1'b0, 32'h0);
      run_check(1, "b sb", OP_SB, 32'h11, 32'h000000A5, 32'(model_mem[1][5]), 6, 1'b0, 32'h88A5AABB);
      for (int n = 0; n < 60; n++) rand_txn(1, LAT_B, "rand_b");

      @(posedge clk); #1;
      check32("a protocol violations", a_bad, 32'd0);
      check32("b protocol violations", b_bad, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
